// File: rtl/call_stack.sv
// Hardware return-address LIFO beside the register file; zero-latency top read.
// Optional STACK_HWM_EN macro enables the high-water-mark register.
module call_stack #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 8,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  stack_overflow,
  output logic                  stack_underflow,
  output logic [CW-1:0]         high_water
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         sp;
  logic [CW-1:0]         sp_next;
  logic [AW-1:0]         top_idx;
  logic [AW-1:0]         wr_idx;
  logic                  wr_en;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  ovf_q;
  logic                  unf_q;

  assign count           = sp;
  assign empty           = (sp == '0);
  assign full            = (sp == FULL_CNT);
  assign top_idx         = AW'(sp - CW'(1));
  assign top_data        = empty ? '0 : mem[top_idx];
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

  // Push+pop on a non-empty stack rewrites the top in place; on an
  // empty stack it degrades to a plain push (empty implies not full).
  always_comb begin
    sp_next = sp;
    wr_en   = 1'b0;
    wr_idx  = AW'(sp);
    ovf_set = 1'b0;
    unf_set = 1'b0;
    priority case (1'b1)
      push && pop && !empty: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      push && !full: begin
        wr_en   = 1'b1;
        sp_next = sp + CW'(1);
      end
      push:           ovf_set = 1'b1;
      pop && !empty:  sp_next = sp - CW'(1);
      pop:            unf_set = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp    <= sp_next;
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[wr_idx] <= push_data;
  end

`ifdef STACK_HWM_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk) begin
    if (rst)
      hwm_q <= '0;
    else if (sp_next > hwm_q)
      hwm_q <= sp_next;
  end

  assign high_water = hwm_q;
`else
  assign high_water = '0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed steps then random traffic
// against a queue-based LIFO model.
module tb_call_stack;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic          pop;
  logic [DW-1:0] push_data;
  logic [DW-1:0] top_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          stack_overflow;
  logic          stack_underflow;
  logic [CW-1:0] high_water;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] q [$];
  bit            m_ovf;
  bit            m_unf;
  int            m_hw;

  call_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .pop            (pop),
    .push_data      (push_data),
    .top_data       (top_data),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .stack_overflow (stack_overflow),
    .stack_underflow(stack_underflow),
    .high_water     (high_water)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit r, input bit pu, input bit po,
                                input logic [DW-1:0] d);
    if (r) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_hw  = 0;
      return;
    end
    if (pu && po) begin
      if (q.size() == 0) q.push_back(d);
      else q[q.size()-1] = d;
    end else if (pu) begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back(d);
    end else if (po) begin
      if (q.size() == 0) m_unf = 1;
      else void'(q.pop_back());
    end
`ifdef STACK_HWM_EN
    if (q.size() > m_hw) m_hw = q.size();
`endif
  endfunction

  task automatic check_all(input string tag);
    logic [DW-1:0] etop;
    etop = (q.size() == 0) ? '0 : q[q.size()-1];
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, ".full"},  64'(full),  64'(q.size() == DEPTH));
    chk({tag, ".ovf"},   64'(stack_overflow),  64'(m_ovf));
    chk({tag, ".unf"},   64'(stack_underflow), 64'(m_unf));
    chk({tag, ".top"},   64'(top_data), 64'(etop));
    chk({tag, ".hw"},    64'(high_water), 64'(m_hw));
  endtask

  task automatic step(input string tag, input bit r, input bit pu,
                      input bit po, input logic [DW-1:0] d);
    rst       = r;
    push      = pu;
    pop       = po;
    push_data = d;
    @(posedge clk);
    model(r, pu, po, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    // 1: reset then idle
    step("rst0", 1, 0, 0, 0);
    step("rst1", 1, 0, 0, 0);
    step("idle", 0, 0, 0, 0);
    chk("reset_top", 64'(top_data), 64'h0);
    // 2: push three, pop three
    step("p11", 0, 1, 0, 32'h11);
    step("p22", 0, 1, 0, 32'h22);
    step("p33", 0, 1, 0, 32'h33);
    chk("lifo_top33", 64'(top_data), 64'h33);
    step("pop1", 0, 0, 1, 0);
    chk("lifo_top22", 64'(top_data), 64'h22);
    step("pop2", 0, 0, 1, 0);
    chk("lifo_top11", 64'(top_data), 64'h11);
    step("pop3", 0, 0, 1, 0);
    chk("lifo_empty", 64'(empty), 64'h1);
    // 3: fill, overflow, pop
    for (int i = 0; i < DEPTH; i++)
      step("fill", 0, 1, 0, 32'h100 + i);
    step("ovf", 0, 1, 0, 32'hFF);
    chk("ovf_top", 64'(top_data), 64'h107);
    chk("ovf_flag", 64'(stack_overflow), 64'h1);
    step("full_repl", 0, 1, 1, 32'h5A5A);
    step("ovf_pop", 0, 0, 1, 0);
    chk("ovf_sticky", 64'(stack_overflow), 64'h1);
    // 4: replace top, push&pop on empty
    step("r4", 1, 0, 0, 0);
    step("pA0", 0, 1, 0, 32'hA0);
    step("pAA", 0, 1, 0, 32'hAA);
    step("repl", 0, 1, 1, 32'hBB);
    chk("repl_top", 64'(top_data), 64'hBB);
    step("pp1", 0, 0, 1, 0);
    step("pp2", 0, 0, 1, 0);
    step("pp_empty", 0, 1, 1, 32'hCC);
    chk("pp_empty_top", 64'(top_data), 64'hCC);
    chk("pp_empty_unf", 64'(stack_underflow), 64'h0);
    // 5: underflow sticky, reset mid-push
    step("r5", 1, 0, 0, 0);
    step("unf", 0, 0, 1, 0);
    chk("unf_flag", 64'(stack_underflow), 64'h1);
    step("unf_p01", 0, 1, 0, 32'h01);
    chk("unf_sticky", 64'(stack_underflow), 64'h1);
    step("rst_push", 1, 1, 0, 32'hDEAD);
    chk("rst_push_cnt", 64'(count), 64'h0);
    // 6: high water
    step("r6", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("hw_p", 0, 1, 0, 32'h200 + i);
    for (int i = 0; i < 3; i++) step("hw_o", 0, 0, 1, 0);
    step("hw_p1", 0, 1, 0, 32'h300);
`ifdef STACK_HWM_EN
    chk("hwm_val", 64'(high_water), 64'd5);
`else
    chk("hwm_val", 64'(high_water), 64'd0);
`endif
    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit r, pu, po;
      r  = ($urandom_range(0, 59) == 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      step("rand", r, pu, po, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
